parallel_to_serial: RTL and testbench
=====================================

Name: parallel_to_serial

Overview:
- Serializer that sits directly upstream of serial_to_parallel.
- Accepts width-bit words on a valid/ready interface and emits them one bit per accepted beat, LSB first. This is the order serial_to_parallel reassembles, so a loopback restores the original word.
- A one-word holding buffer lets the next word be accepted while the current one shifts out, giving gap-free back-to-back words.
- Downstream backpressure is via serial_ready.

Parameters:
- width, 8, bits per parallel word; legal range is 2 or more.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- parallel_valid  input  1  upstream word present
- parallel_data  input  width  upstream word
- parallel_ready  output  1  block can take a word this cycle
- serial_valid  output  1  serial_data holds a valid bit
- serial_data  output  1  current bit, LSB of the word first
- serial_ready  input  1  downstream consumes the bit this cycle
- busy  output  1  shifter or hold buffer is occupied

Behaviour:
- State:
  - shifter sh[width-1:0]
  - bit counter cnt, $clog2(width) bits
  - active flag
  - hold_valid flag and hold_data[width-1:0]
- Reset (rst sampled high at posedge): active=0, hold_valid=0, cnt=0, sh=0, hold_data=0.
- Output values while rst is high and on the first cycle after: serial_valid=0, serial_data=0, busy=0, parallel_ready=0 while rst is high.
- Reset mid-word drops the word in flight and any held word. No partial bits are emitted afterwards.
- Output equations:
  - parallel_ready = !rst && !hold_valid
  - serial_valid = active
  - serial_data = sh[0]
  - busy = active || hold_valid
  - These are combinational from registers only. serial_data is 0 whenever active=0.
- Handshakes:
  - A word is accepted when parallel_valid && parallel_ready at posedge.
  - A bit is consumed when serial_valid && serial_ready at posedge.
  - Once serial_valid is high it stays high, with stable serial_data, until the bit is consumed.
- Latency: a word accepted at edge N into an idle block makes serial_valid=1 with bit 0 during the cycle after edge N.
- Consume, not last bit (cnt != width-1): sh <= sh >> 1, cnt <= cnt+1.
- Consume, last bit (cnt == width-1): cnt <= 0, then
  - if hold_valid: sh <= hold_data, hold_valid <= 0, active stays 1 (no bubble);
  - else if accept this cycle: sh <= parallel_data, active stays 1 (no bubble);
  - else: active <= 0, sh <= 0.
- Accept while idle (active=0): sh <= parallel_data, cnt <= 0, active <= 1.
- Accept while active and not the last-bit consume: hold_data <= parallel_data, hold_valid <= 1.
- Simultaneous events:
  - Accept and non-last consume in the same cycle: the word goes to hold.
  - Accept and last consume with hold empty: direct load into sh.
  - Accept with hold full cannot happen, since parallel_ready=0.
- Stall: serial_ready=0 freezes sh, cnt and active. hold_valid may still fill.
- Throughput: with serial_ready held at 1 and words always offered, serial_valid stays continuously high at 1 bit/cycle. parallel_ready is high for 1 cycle in every width cycles in steady state.
- parallel_data is ignored unless a word is accepted. X on parallel_data is tolerated when parallel_valid=0.

Decomposition:
- No shared package: the block has no typedefs and no cross-module constants.
- Counter width is a localparam, $clog2(width).
- Single module, no sub-modules. The hold buffer is two registers and is not worth a separate block.

Test Plan:
- Single word, width=8: after reset, drive 8'hA5 for 1 cycle with serial_ready=1 -> serial_valid high for exactly 8 cycles, serial_data = 1,0,1,0,0,1,0,1; busy then drops, sh=0.
- Back-to-back words: offer 8'h01, 8'hFF, 8'h80 continuously with serial_ready=1 -> 24 consecutive valid bits with no gap. parallel_ready pulses once per 8 cycles after the hold buffer fills.
- Backpressure: word 8'h3C with serial_ready toggling 1,0,0,1,... -> each bit is held stable while serial_ready=0. Bit order 0,0,1,1,1,1,0,0 is preserved. Exactly 8 consumes occur.
- Hold full: while the first word shifts, offer a second and a third word -> the second is accepted into hold. parallel_ready=0 until the first word's last bit is consumed, then the third is accepted.
- Reset mid-operation: assert rst after 3 bits of 8'hC3 with a word held -> next cycle serial_valid=0, busy=0, parallel_ready=1. A new 8'h5A then shifts out cleanly from bit 0.
- Loopback with serial_to_parallel (width=8), serial_valid/serial_data wired across, serial_ready=1: send 100 random words -> each parallel_data output equals the sent word, in order.

Source files
------------

// File: rtl/parallel_to_serial_if.sv
// Word-in / bit-out handshake bundle for the serializer.
// slave is the serializer's view; master is the view of whoever drives it.
interface parallel_to_serial_if #(
  parameter int width = 8
);
  logic             parallel_valid;
  logic [width-1:0] parallel_data;
  logic             parallel_ready;
  logic             serial_valid;
  logic             serial_data;
  logic             serial_ready;
  logic             busy;

  modport slave (
    input  parallel_valid, parallel_data, serial_ready,
    output parallel_ready, serial_valid, serial_data, busy
  );

  modport master (
    output parallel_valid, parallel_data, serial_ready,
    input  parallel_ready, serial_valid, serial_data, busy
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Serializer: accepts width-bit words and emits them LSB first, one bit per
// consumed beat. A one-word hold buffer lets the next word arrive while the
// current one shifts, so back-to-back words leave without a bubble.
module parallel_to_serial #(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst,
  parallel_to_serial_if.slave bus
);
  localparam int CNT_W = $clog2(width);

  logic [width-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic             r_hold_valid;
  logic [width-1:0] r_hold_data;

  logic [width-1:0] w_sh_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_active_next;
  logic             w_hold_valid_next;
  logic [width-1:0] w_hold_data_next;

  logic w_parallel_ready;
  logic w_accept;
  logic w_consume;
  logic w_last;

  // Outputs depend only on registers (plus rst gating the ready).
  assign w_parallel_ready   = !rst && !r_hold_valid;
  assign bus.parallel_ready = w_parallel_ready;
  assign bus.serial_valid   = r_active;
  assign bus.serial_data    = r_sh[0];
  assign bus.busy           = r_active || r_hold_valid;

  assign w_accept  = bus.parallel_valid && w_parallel_ready;
  assign w_consume = r_active && bus.serial_ready;
  assign w_last    = (r_cnt == CNT_W'(width - 1));

  // Next-state: shift on consume, refill from hold or input on the last bit,
  // park an incoming word in hold while a word is still in flight.
  always_comb begin
    w_sh_next         = r_sh;
    w_cnt_next        = r_cnt;
    w_active_next     = r_active;
    w_hold_valid_next = r_hold_valid;
    w_hold_data_next  = r_hold_data;

    if (w_consume) begin
      if (!w_last) begin
        w_sh_next  = r_sh >> 1;
        w_cnt_next = r_cnt + CNT_W'(1);
      end else begin
        w_cnt_next = '0;
        if (r_hold_valid) begin
          w_sh_next         = r_hold_data;
          w_hold_valid_next = 1'b0;
        end else if (w_accept) begin
          w_sh_next = bus.parallel_data;
        end else begin
          w_active_next = 1'b0;
          w_sh_next     = '0;
        end
      end
    end

    // Accept into the shifter when idle; otherwise into hold, except when the
    // last bit is leaving this cycle and the word was loaded directly above.
    if (w_accept) begin
      if (!r_active) begin
        w_sh_next     = bus.parallel_data;
        w_cnt_next    = '0;
        w_active_next = 1'b1;
      end else if (!(w_consume && w_last)) begin
        w_hold_data_next  = bus.parallel_data;
        w_hold_valid_next = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh         <= '0;
      r_cnt        <= '0;
      r_active     <= 1'b0;
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else begin
      r_sh         <= w_sh_next;
      r_cnt        <= w_cnt_next;
      r_active     <= w_active_next;
      r_hold_valid <= w_hold_valid_next;
      r_hold_data  <= w_hold_data_next;
    end
  end
endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: a fixed vector table, directed multi-cycle
// sequences and a random run, all checked every cycle against a bit-queue
// model, plus a receiver that reassembles observed bits into words.
module tb_parallel_to_serial;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parallel_to_serial_if #(.width(W)) bus ();

  parallel_to_serial #(.width(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic         r;
    logic         pv;
    logic [W-1:0] pd;
    logic         sr;
    logic         ev;
    logic         ed;
    logic         er;
    logic         eb;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: bits still owed by the block, oldest first. A word occupies W
  // entries from acceptance until its last bit is consumed.
  bit           exp_bits[$];
  logic [W-1:0] sent_q[$];
  // Receiver built from what the DUT actually emits.
  logic [W-1:0] rx_word;
  int           rx_cnt;

  bit   last_accept, last_consume;
  logic obs_valid, obs_data, obs_ready, obs_busy;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_ready(input logic r);
    return !r && (exp_bits.size() <= W);
  endfunction

  // One clock cycle: drive, compare before the edge, advance model at the edge.
  task automatic cycle_v(input vec_t v, input bit use_tbl);
    bit b;
    rst = v.r;
    bus.parallel_valid = v.pv;
    bus.parallel_data  = v.pd;
    bus.serial_ready   = v.sr;
    #3;
    obs_valid = bus.serial_valid;
    obs_data  = bus.serial_data;
    obs_ready = bus.parallel_ready;
    obs_busy  = bus.busy;
    check1("serial_valid", obs_valid, exp_bits.size() > 0);
    check1("serial_data", obs_data, (exp_bits.size() > 0) ? exp_bits[0] : 1'b0);
    check1("parallel_ready", obs_ready, m_ready(v.r));
    check1("busy", obs_busy, exp_bits.size() > 0);
    if (use_tbl) begin
      check1("tbl_valid", obs_valid, v.ev);
      check1("tbl_data", obs_data, v.ed);
      check1("tbl_ready", obs_ready, v.er);
      check1("tbl_busy", obs_busy, v.eb);
    end
    // Receiver: collect bits the DUT presents on consuming beats.
    if (!v.r && obs_valid === 1'b1 && v.sr) begin
      rx_word[rx_cnt] = obs_data;
      rx_cnt++;
      if (rx_cnt == W) begin
        n_checks++;
        if (sent_q.size() == 0) begin
          n_fail++;
          $display("FAIL rx_word cycle %0d: got %h expected no word", cyc, rx_word);
        end else begin
          logic [W-1:0] e;
          e = sent_q.pop_front();
          if (rx_word !== e) begin
            n_fail++;
            $display("FAIL rx_word cycle %0d: got %h expected %h", cyc, rx_word, e);
          end
        end
        rx_cnt = 0;
      end
    end
    last_accept  = !v.r && v.pv && m_ready(v.r);
    last_consume = !v.r && (exp_bits.size() > 0) && v.sr;
    @(posedge clk);
    if (v.r) begin
      exp_bits.delete();
      sent_q.delete();
      rx_cnt = 0;
    end else begin
      if (last_consume) b = exp_bits.pop_front();
      if (last_accept) begin
        for (int i = 0; i < W; i++) exp_bits.push_back(v.pd[i]);
        sent_q.push_back(v.pd);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic cycle(input logic r, input logic pv, input logic [W-1:0] pd, input logic sr);
    vec_t v;
    v.r = r; v.pv = pv; v.pd = pd; v.sr = sr;
    v.ev = 1'b0; v.ed = 1'b0; v.er = 1'b0; v.eb = 1'b0;
    cycle_v(v, 1'b0);
  endtask

  function automatic vec_t mk(input logic r, input logic pv, input logic [W-1:0] pd,
                              input logic sr, input logic ev, input logic ed,
                              input logic er, input logic eb);
    vec_t v;
    v.r = r; v.pv = pv; v.pd = pd; v.sr = sr;
    v.ev = ev; v.ed = ed; v.er = er; v.eb = eb;
    return v;
  endfunction

  initial begin
    vec_t         tbl[12];
    logic [W-1:0] words[3];
    int idx, first_v, last_v, nvalid, ncons, a1, a2, a3, guard, sent;

    // Single word 8'hA5: bits 1,0,1,0,0,1,0,1, LSB first.
    tbl[0]  = mk(1, 0, 8'h00, 1,  0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'hA5, 1,  0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 8'h00, 1,  1, 1, 1, 1);
    tbl[3]  = mk(0, 0, 8'h00, 1,  1, 0, 1, 1);
    tbl[4]  = mk(0, 0, 8'h00, 1,  1, 1, 1, 1);
    tbl[5]  = mk(0, 0, 8'h00, 1,  1, 0, 1, 1);
    tbl[6]  = mk(0, 0, 8'h00, 1,  1, 0, 1, 1);
    tbl[7]  = mk(0, 0, 8'h00, 1,  1, 1, 1, 1);
    tbl[8]  = mk(0, 0, 8'h00, 1,  1, 0, 1, 1);
    tbl[9]  = mk(0, 0, 8'h00, 1,  1, 1, 1, 1);
    tbl[10] = mk(0, 0, 8'h00, 1,  0, 0, 1, 0);
    tbl[11] = mk(0, 0, 8'h00, 1,  0, 0, 1, 0);

    rx_cnt = 0;
    rx_word = '0;
    rst = 1'b1;
    bus.parallel_valid = 1'b0;
    bus.parallel_data  = '0;
    bus.serial_ready   = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) cycle_v(tbl[i], 1'b1);

    // Back-to-back words: 24 contiguous valid bits.
    words[0] = 8'h01; words[1] = 8'hFF; words[2] = 8'h80;
    idx = 0; first_v = -1; last_v = -1; nvalid = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, idx < 3, (idx < 3) ? words[idx] : 8'h00, 1);
      if (obs_valid === 1'b1) begin
        nvalid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (last_accept) idx++;
    end
    check_int("b2b_valid_count", nvalid, 24);
    check_int("b2b_valid_span", last_v - first_v + 1, 24);

    // Backpressure: serial_ready 1,0,0 repeating; exactly 8 consumes.
    cycle(0, 1, 8'h3C, 1);
    ncons = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(0, 0, 8'h00, (i % 3) == 0);
      if (obs_valid === 1'b1 && (i % 3) == 0) ncons++;
    end
    check_int("bp_consumes", ncons, 8);

    // Hold full: second word goes to hold, third waits for first's last bit.
    a1 = -1; a2 = -1; a3 = -1; guard = 0;
    while (a3 < 0 && guard < 40) begin
      if (a1 < 0)      cycle(0, 1, 8'h11, 1);
      else if (a2 < 0) cycle(0, 1, 8'h22, 1);
      else             cycle(0, 1, 8'h33, 1);
      if (last_accept) begin
        if (a1 < 0) a1 = cyc; else if (a2 < 0) a2 = cyc; else a3 = cyc;
      end
      guard++;
    end
    check_int("hold_second_accept", a2 - a1, 1);
    check_int("hold_third_accept", a3 - a1, W + 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 8'h00, 1);

    // Reset mid-word with a word held, then a clean 8'h5A.
    cycle(0, 1, 8'hC3, 1);
    cycle(0, 1, 8'h99, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'h5A, 1);
    check1("rst_valid", obs_valid, 1'b0);
    check1("rst_busy", obs_busy, 1'b0);
    check1("rst_ready", obs_ready, 1'b1);
    for (int i = 0; i < 12; i++) cycle(0, 0, 8'h00, 1);
    check_int("rst_words_left", sent_q.size(), 0);

    // Random traffic: 100 words with random valid, data and backpressure.
    sent = 0; guard = 0;
    while (sent < 100 && guard < 5000) begin
      cycle(0, ($urandom % 4) != 0, W'($urandom), ($urandom % 4) != 0);
      if (last_accept) sent++;
      guard++;
    end
    check_int("rand_words_sent", sent, 100);
    for (int i = 0; i < 30; i++) cycle(0, 0, 8'h00, 1);
    check_int("rand_words_left", sent_q.size(), 0);
    check_int("rand_partial_bits", rx_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
